// File: rtl/div48x16_pkg.sv
// Shared constants, state encoding and helpers for the div48x16 signed divider.
package div48x16_pkg;
    localparam int DW_A  = 48;
    localparam int DW_B  = 16;
    localparam int DW_Q  = 32;
    localparam int CNT_W = 6;

    localparam logic [DW_Q-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [DW_Q-1:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // |-2^47| = 2^47 still fits as an unsigned 48-bit magnitude
    function automatic logic [DW_A-1:0] abs_a(input logic [DW_A-1:0] v);
        return v[DW_A-1] ? -v : v;
    endfunction
endpackage

// File: rtl/div48x16_if.sv
// Request/result bundle of the div48x16 divider; master drives operands, slave returns results.
interface div48x16_if;
    import div48x16_pkg::*;

    logic            ce;
    logic            start;
    logic [DW_A-1:0] a;
    logic [DW_B-1:0] b;
    logic [DW_Q-1:0] dout_q;
    logic [DW_B-1:0] dout_r;
    logic            valid;
    logic            busy;
    logic            dz;
    logic            ovf;

    modport master (
        output ce, start, a, b,
        input  dout_q, dout_r, valid, busy, dz, ovf
    );

    modport slave (
        input  ce, start, a, b,
        output dout_q, dout_r, valid, busy, dz, ovf
    );
endinterface

// File: rtl/div48x16_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor when it fits.
module div_step (
    input  logic [16:0] rem_in,
    input  logic        bit_in,
    input  logic [16:0] dvsr,
    output logic [16:0] rem_out,
    output logic        q_bit
);
    logic [17:0] w_shift;
    logic [16:0] w_diff;

    assign w_shift = {rem_in, bit_in};
    assign q_bit   = (w_shift >= {1'b0, dvsr});
    // Only taken when q_bit=1, so the result is below dvsr and the dropped MSB is zero
    assign w_diff  = w_shift[16:0] - dvsr;
    assign rem_out = q_bit ? w_diff : w_shift[16:0];
endmodule

// File: rtl/div48x16.sv
// Sequential 48/16 signed divider, one quotient bit per enabled clock, saturating quotient.
// Define DIV48X16_ROUND_EN to round the quotient half away from zero.
module div48x16
    import div48x16_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    div48x16_if.slave bus
);
    localparam logic [DW_A:0] NEG_LIM = {{(DW_A+1-DW_Q){1'b0}}, Q_MIN};
    localparam logic [DW_A:0] POS_LIM = {{(DW_A+1-DW_Q){1'b0}}, Q_MAX};

    state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [DW_A-1:0] r_mag;
    logic [DW_B:0]   r_rem, r_dvsr, w_rem_nxt;
    logic [DW_B:0]   w_b_ext, w_b_mag;
    logic            r_sa, r_sb, r_bz;
    logic            w_qbit, w_accept, w_calc_en, w_fix_en, w_load_out;
    logic [DW_A:0]   w_qm;
    logic            w_neg;
    logic [DW_Q-1:0] r_dout_q, w_fix_q;
    logic [DW_B-1:0] r_dout_r, w_fix_r;
    logic            r_valid, r_dz, r_ovf, w_fix_ovf;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (bus.b == '0) ? FIX : CALC;
            CALC:    if (w_calc_en && r_cnt == '0) w_state_nxt = FIX;
            FIX:     if (w_fix_en) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_accept   = 1'b0;
        w_calc_en  = 1'b0;
        w_fix_en   = 1'b0;
        w_load_out = 1'b0;
        bus.busy   = 1'b1;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
                w_accept = bus.ce & bus.start;
            end
            CALC:    w_calc_en  = bus.ce;
            FIX:     w_fix_en   = bus.ce;
            DONE:    w_load_out = 1'b1;
            default: bus.busy   = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    assign w_b_ext = {bus.b[DW_B-1], bus.b};
    assign w_b_mag = w_b_ext[DW_B] ? -w_b_ext : w_b_ext;

    div_step u_step (
        .rem_in  (r_rem),
        .bit_in  (r_mag[DW_A-1]),
        .dvsr    (r_dvsr),
        .rem_out (w_rem_nxt),
        .q_bit   (w_qbit)
    );

    // r_mag shifts the dividend out at the top while quotient bits enter at the bottom
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_mag  <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_bz   <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= CNT_W'(DW_A-1);
            r_mag  <= abs_a(bus.a);
            r_rem  <= '0;
            r_dvsr <= w_b_mag;
            r_sa   <= bus.a[DW_A-1];
            r_sb   <= bus.b[DW_B-1];
            r_bz   <= (bus.b == '0);
        end else if (w_calc_en) begin
            r_cnt  <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            r_mag  <= {r_mag[DW_A-2:0], w_qbit};
            r_rem  <= w_rem_nxt;
        end
    end

    // ---------------- sign fix and saturation ----------------
`ifdef DIV48X16_ROUND_EN
    logic w_rnd;
    assign w_rnd = ({r_rem, 1'b0} >= {1'b0, r_dvsr});
    assign w_qm  = {1'b0, r_mag} + {{DW_A{1'b0}}, w_rnd};
`else
    assign w_qm  = {1'b0, r_mag};
`endif

    assign w_neg = r_sa ^ r_sb;

    always_comb begin
        w_fix_q   = '0;
        w_fix_r   = '0;
        w_fix_ovf = 1'b0;
        if (r_bz) begin
            w_fix_q = r_sa ? Q_MIN : Q_MAX;
        end else begin
            w_fix_r = r_sa ? -r_rem[DW_B-1:0] : r_rem[DW_B-1:0];
            if (w_neg) begin
                // magnitude 2^31 is still representable as a negative quotient
                if (w_qm > NEG_LIM) begin
                    w_fix_q   = Q_MIN;
                    w_fix_ovf = 1'b1;
                end else begin
                    w_fix_q   = -w_qm[DW_Q-1:0];
                end
            end else if (w_qm > POS_LIM) begin
                w_fix_q   = Q_MAX;
                w_fix_ovf = 1'b1;
            end else begin
                w_fix_q   = w_qm[DW_Q-1:0];
            end
        end
    end

    // Results are registered out of DONE regardless of ce, so valid is a clean one-clk pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dout_q <= '0;
            r_dout_r <= '0;
            r_valid  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= w_load_out;
            if (w_load_out) begin
                r_dout_q <= w_fix_q;
                r_dout_r <= w_fix_r;
                r_dz     <= r_bz;
                r_ovf    <= w_fix_ovf;
            end
        end
    end

    assign bus.dout_q = r_dout_q;
    assign bus.dout_r = r_dout_r;
    assign bus.valid  = r_valid;
    assign bus.dz     = r_dz;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_div48x16.sv
// Directed self-checking bench for div48x16 (optionally built with DIV48X16_ROUND_EN).
module tb_div48x16;
    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    div48x16_if bus();

    div48x16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one operation from IDLE; returns edges from the start-sampling edge to valid (-1 on timeout)
    task automatic run_op(input logic [47:0] ta, input logic [15:0] tb_v,
                          input int off_at, input int off_len, output int lat);
        bus.a = ta;
        bus.b = tb_v;
        bus.ce = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = n;
                break;
            end
            if (n == off_at) bus.ce = 1'b0;
            if (n == off_at + off_len) bus.ce = 1'b1;
        end
        bus.ce = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.valid, bus.busy, bus.dz, bus.ovf} !== 52'h0) begin
            errs++;
            $display("FAIL reset_state: got q=%h r=%h v=%b busy=%b dz=%b ovf=%b want all 0",
                     bus.dout_q, bus.dout_r, bus.valid, bus.busy, bus.dz, bus.ovf);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        run_op(48'd6000, 16'd7, 0, 0, lat);
        vecs++;
        if (lat !== 50) begin errs++; $display("FAIL basic_latency: got %0d want 50", lat); end
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'd857, 16'd1, 2'b00}) begin
            errs++;
            $display("FAIL basic_result: got q=%h r=%h dz=%b ovf=%b want q=00000359 r=0001 dz=0 ovf=0",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
        vecs++;
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL basic_busy_at_valid: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        vecs++;
        if (bus.valid !== 1'b0) begin errs++; $display("FAIL basic_valid_width: got %b want 0", bus.valid); end
        vecs++;
        if (bus.dout_q !== 32'd857) begin errs++; $display("FAIL basic_hold: got %h want 00000359", bus.dout_q); end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] exp_q;
`ifdef DIV48X16_ROUND_EN
        exp_q = 32'hFFFF_FFFC;
`else
        exp_q = 32'hFFFF_FFFD;
`endif
        run_op(-48'sd7, 16'd2, 0, 0, lat);
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {exp_q, 16'hFFFF, 2'b00}) begin
            errs++;
            $display("FAIL signed_neg7_div2: got q=%h r=%h dz=%b ovf=%b want q=%h r=ffff dz=0 ovf=0",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf, exp_q);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(48'd5, 16'd0, 0, 0, lat);
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'h7FFF_FFFF, 16'h0, 2'b10}) begin
            errs++;
            $display("FAIL dz_pos: got q=%h r=%h dz=%b ovf=%b want q=7fffffff r=0000 dz=1 ovf=0",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
        @(posedge clk); #1;
        run_op(-48'sd5, 16'd0, 0, 0, lat);
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'h8000_0000, 16'h0, 2'b10}) begin
            errs++;
            $display("FAIL dz_neg: got q=%h r=%h dz=%b ovf=%b want q=80000000 r=0000 dz=1 ovf=0",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(48'h0100_0000_0000, 16'd1, 0, 0, lat);
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'h7FFF_FFFF, 16'h0, 2'b01}) begin
            errs++;
            $display("FAIL ovf_2p40: got q=%h r=%h dz=%b ovf=%b want q=7fffffff r=0000 dz=0 ovf=1",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
        @(posedge clk); #1;
        run_op(48'hFFFF_8000_0000, 16'd1, 0, 0, lat);
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'h8000_0000, 16'h0, 2'b00}) begin
            errs++;
            $display("FAIL ovf_min_edge: got q=%h r=%h dz=%b ovf=%b want q=80000000 r=0000 dz=0 ovf=0",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
        @(posedge clk); #1;
        run_op(48'hFFFF_8000_0000, 16'hFFFF, 0, 0, lat);
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'h7FFF_FFFF, 16'h0, 2'b01}) begin
            errs++;
            $display("FAIL ovf_min_div_m1: got q=%h r=%h dz=%b ovf=%b want q=7fffffff r=0000 dz=0 ovf=1",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int nval;
        int first_lat;
        logic [31:0] first_q;
        logic busy_at_2nd;
        nval = 0;
        first_lat = -1;
        first_q = '0;
        busy_at_2nd = 1'b0;
        @(posedge clk); #1;
        bus.a = 48'd6000;
        bus.b = 16'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                nval++;
                if (first_lat < 0) begin first_lat = n; first_q = bus.dout_q; end
            end
            if (n == 10) begin
                bus.a = 48'd100;
                bus.b = 16'd3;
                bus.start = 1'b1;
                busy_at_2nd = bus.busy;
            end else begin
                bus.start = 1'b0;
            end
        end
        vecs++;
        if (busy_at_2nd !== 1'b1) begin errs++; $display("FAIL b2b_busy: got %b want 1", busy_at_2nd); end
        vecs++;
        if (nval !== 1) begin errs++; $display("FAIL b2b_valid_count: got %0d want 1", nval); end
        vecs++;
        if ({first_lat, first_q} !== {32'd50, 32'd857}) begin
            errs++;
            $display("FAIL b2b_first_result: got lat=%0d q=%h want lat=50 q=00000359", first_lat, first_q);
        end

        // Reset mid-operation discards it
        bus.a = 48'd1000;
        bus.b = 16'd10;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (18) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.valid, bus.busy, bus.dz, bus.ovf} !== 52'h0) begin
            errs++;
            $display("FAIL midreset_state: got q=%h r=%h v=%b busy=%b dz=%b ovf=%b want all 0",
                     bus.dout_q, bus.dout_r, bus.valid, bus.busy, bus.dz, bus.ovf);
        end
        reset = 1'b1;
        nval = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (bus.valid) nval++;
        end
        vecs++;
        if (nval !== 0) begin errs++; $display("FAIL midreset_no_valid: got %0d want 0", nval); end
    endtask

    task automatic test_ce_stall();
        int lat;
        run_op(48'hFFFF_FFFE_8000, 16'h8000, 5, 10, lat);
        vecs++;
        if (lat !== 60) begin errs++; $display("FAIL ce_latency: got %0d want 60", lat); end
        vecs++;
        if ({bus.dout_q, bus.dout_r, bus.dz, bus.ovf} !== {32'd3, 16'h0, 2'b00}) begin
            errs++;
            $display("FAIL ce_result: got q=%h r=%h dz=%b ovf=%b want q=00000003 r=0000 dz=0 ovf=0",
                     bus.dout_q, bus.dout_r, bus.dz, bus.ovf);
        end
        @(posedge clk); #1;
        vecs++;
        if (bus.valid !== 1'b0) begin errs++; $display("FAIL ce_valid_width: got %b want 0", bus.valid); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        bus.ce = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_ce_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
